aes128_dec: RTL and testbench
=============================

// Module: aes128_dec
// PURPOSE
//  Iterative AES-128 decryptor (FIPS-197 inverse cipher); one round per clock.
//  Receive-side counterpart of the AES-128 encryption core in the crypto accelerator.
//  Runs the forward key expansion to round key 10, then walks the key schedule backwards during the rounds.
//  No round-key RAM.
// PARAMETERS
//  ROUNDS    10      AES-128 round count; only 10 is legal (elaboration error otherwise)
//  PT_RST    128'd0  reset/clear value of plaintext
// PORTS
//  clk         in   1    single clock, rising edge
//  reset_n     in   1    asynchronous, active-low reset
//  start       in   1    request; sampled only in IDLE
//  ciphertext  in   128  block to decrypt; byte0 = [127:120], column-major per FIPS-197
//  key         in   128  cipher key, same byte order
//  plaintext   out  128  result; registered, held until next completion
//  done        out  1    one-cycle registered pulse; plaintext valid from the same edge
//  busy        out  1    high in every state except IDLE
// BEHAVIOUR
//  Reset: FSM=IDLE, plaintext=PT_RST, done=0, busy=0, round_count=0, state/key regs=0.
//  FSM: IDLE -> KEYEX -> INIT -> ROUND -> FINAL -> DONE_ST -> IDLE.
//  IDLE: start=1 captures ciphertext into state_reg and key into round_key_reg; round_count=0; -> KEYEX.
//  KEYEX: 10 cycles.
//   - Each cycle: forward key step (RotWord, SubWord, Rcon[round_count+1]); round_count++.
//   - At round_count=10 -> INIT.
//  INIT: state ^= k10; round_count=9; -> ROUND.
//  ROUND: 9 cycles, r = 9..1.
//   - Key step: k(r) from k(r+1) via the inverse key step, using Rcon[r+1].
//   - Data: state = InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ k(r)).
//   - round_count--; at r=1 -> FINAL.
//  FINAL: inverse key step to k0; plaintext <= InvSubBytes(InvShiftRows(state)) ^ k0; done<=1.
//  DONE_ST: done<=0; -> IDLE once start=0 (a held start does not retrigger).
//  Latency: the start-sample edge is edge 0; plaintext/done update on edge 21 (no cache hit).
//  S-box: forward and inverse both built from one GF(2^8) inverse (poly 0x11B) plus an affine / inverse-affine map.
//   - No 256-entry tables.
//   - GF inverse maps 0x00 to 0x00.
//  Rcon: {01,02,04,08,10,20,40,80,1B,36} indexed 1..10; round_count is 4 bits, never wraps.
//  start while busy=1: ignored; inputs are not re-sampled; the operation in flight is undisturbed.
//  ciphertext/key may change after the start-sample edge without effect.
//  reset_n low mid-operation: immediate return to reset values; no done pulse; partial result discarded.
//  done and busy are never both 0 in DONE_ST: busy stays 1 there.
// CONFIGURATION
//  AES_DEC_KEYCACHE_EN defined:
//   - Adds last_key (128b), k10_cache (128b) and cache_valid regs, all cleared by reset.
//   - On entering INIT: k10_cache<=k10, last_key<=captured key, cache_valid<=1.
//   - In IDLE, if start=1 and cache_valid=1 and key==last_key: load k10_cache, skip KEYEX, go straight to INIT.
//   - Cache-hit latency is 11 edges.
//   - A key mismatch runs the full KEYEX and refreshes the cache.
//  AES_DEC_KEYCACHE_EN undefined: none of the above logic exists; KEYEX runs every time; latency is always 21.
// TESTING
//  FIPS-197 C.1: key=000102030405060708090a0b0c0d0e0f, ct=69c4e0d86a7b0430d8cdb78070b4c55a
//   -> pt=00112233445566778899aabbccddeeff, done on edge 21, exactly one pulse.
//  FIPS-197 App.B: key=2b7e151628aed2a6abf7158809cf4f3c, ct=3925841d02dc09fbdc118597196a0b32
//   -> pt=3243f6a8885a308d313198a2e0370734.
//  Toggle start and change ct at edge 5 of a C.1 run -> C.1 result unchanged, single done.
//   - Holding start high after done gives no second done until start drops.
//  Pull reset_n low at edge 12 -> plaintext=0, done=0, busy=0 asynchronously.
//   - A fresh C.1 request then completes correctly.
//  KEYCACHE_EN: two back-to-back C.1 runs -> second done 11 edges after start.
//   - An App.B key next -> 21 edges, correct pt.
//   - Without the macro, all runs take 21 edges.
//  Loopback: 1000 random key/pt pairs through aes128_enc, then this block -> original pt recovered every time.

Source files
------------

// File: rtl/aes128_dec_if.sv
// Request/response bundle for the iterative AES-128 decryptor.
// master drives the request side, slave is the decryptor.
`timescale 1ns/1ps
interface aes128_dec_if;
  logic         start;
  logic [127:0] ciphertext;
  logic [127:0] key;
  logic [127:0] plaintext;
  logic         done;
  logic         busy;

  modport master (
    output start, ciphertext, key,
    input  plaintext, done, busy
  );

  modport slave (
    input  start, ciphertext, key,
    output plaintext, done, busy
  );
endinterface

// File: rtl/aes128_dec.sv
// Iterative AES-128 inverse cipher, one round per clock, no key RAM.
// Optional k10 key cache: define AES_DEC_KEYCACHE_EN.
`timescale 1ns/1ps
module aes128_dec #(
  parameter int unsigned  ROUNDS = 10,
  parameter logic [127:0] PT_RST = 128'd0
) (
  input  logic        clk,
  input  logic        reset_n,
  aes128_dec_if.slave io
);

  if (ROUNDS != 10) begin : g_rounds_chk
    $error("aes128_dec: ROUNDS must be 10");
  end

  localparam logic [3:0] RC_LAST = 4'(ROUNDS - 1);

  typedef enum logic [2:0] {
    IDLE, KEYEX, INIT, ROUND, FINAL, DONE_ST
  } fsm_t;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a,
                                      input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // a^254 == a^-1 in GF(2^8); 0 maps to 0 naturally
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] r;
    sq = gmul(a, a);
    r  = sq;
    for (int i = 0; i < 6; i++) begin
      sq = gmul(sq, sq);
      r  = gmul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b;
    b = ginv(x);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]}
             ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] isbox(input logic [7:0] x);
    logic [7:0] y;
    y = {x[6:0], x[7]} ^ {x[4:0], x[7:5]}
      ^ {x[1:0], x[7:2]} ^ 8'h05;
    return ginv(y);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] inv_shift_rows(
    input logic [127:0] s
  );
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] =
          s[127-8*(4*((c-r+4)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(
    input logic [127:0] s
  );
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++)
      o[127-8*i -: 8] = isbox(s[127-8*i -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b)
                       ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      o[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e)
                       ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      o[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09)
                       ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      o[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d)
                       ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
    end
    return o;
  endfunction

  fsm_t         fsm;
  logic [127:0] state_reg;
  logic [127:0] round_key_reg;
  logic [3:0]   round_count;

`ifdef AES_DEC_KEYCACHE_EN
  logic [127:0] last_key;
  logic [127:0] k10_cache;
  logic         cache_valid;
`endif

  logic [31:0]  kw0, kw1, kw2, kw3;
  logic [31:0]  rw, tw;
  logic [127:0] k_fwd, k_inv;
  logic [127:0] isb;
  logic [127:0] imc;

  assign kw0 = round_key_reg[127:96];
  assign kw1 = round_key_reg[95:64];
  assign kw2 = round_key_reg[63:32];
  assign kw3 = round_key_reg[31:0];

  // forward and inverse key steps share one SubWord
  assign rw = (fsm == KEYEX) ? kw3 : (kw3 ^ kw2);
  assign tw = {sbox(rw[23:16]), sbox(rw[15:8]),
               sbox(rw[7:0]),   sbox(rw[31:24])}
            ^ {rcon(round_count + 4'd1), 24'h0};

  assign k_fwd = {kw0 ^ tw,
                  kw0 ^ tw ^ kw1,
                  kw0 ^ tw ^ kw1 ^ kw2,
                  kw0 ^ tw ^ kw1 ^ kw2 ^ kw3};
  assign k_inv = {kw0 ^ tw, kw0 ^ kw1, kw1 ^ kw2, kw2 ^ kw3};

  assign isb = inv_sub_bytes(inv_shift_rows(state_reg));
  assign imc = inv_mix(isb ^ k_inv);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fsm           <= IDLE;
      state_reg     <= '0;
      round_key_reg <= '0;
      round_count   <= '0;
      io.plaintext  <= PT_RST;
      io.done       <= 1'b0;
      io.busy       <= 1'b0;
`ifdef AES_DEC_KEYCACHE_EN
      last_key      <= '0;
      k10_cache     <= '0;
      cache_valid   <= 1'b0;
`endif
    end else begin
      unique case (fsm)
        IDLE: begin
          if (io.start) begin
            state_reg   <= io.ciphertext;
            round_count <= '0;
            io.busy     <= 1'b1;
`ifdef AES_DEC_KEYCACHE_EN
            if (cache_valid && io.key == last_key) begin
              round_key_reg <= k10_cache;
              fsm           <= INIT;
            end else begin
              round_key_reg <= io.key;
              last_key      <= io.key;
              cache_valid   <= 1'b0;
              fsm           <= KEYEX;
            end
`else
            round_key_reg <= io.key;
            fsm           <= KEYEX;
`endif
          end
        end
        KEYEX: begin
          round_key_reg <= k_fwd;
          round_count   <= round_count + 4'd1;
          if (round_count == RC_LAST) begin
            fsm <= INIT;
`ifdef AES_DEC_KEYCACHE_EN
            k10_cache   <= k_fwd;
            cache_valid <= 1'b1;
`endif
          end
        end
        INIT: begin
          state_reg   <= state_reg ^ round_key_reg;
          round_count <= RC_LAST;
          fsm         <= ROUND;
        end
        ROUND: begin
          state_reg     <= imc;
          round_key_reg <= k_inv;
          round_count   <= round_count - 4'd1;
          if (round_count == 4'd1) fsm <= FINAL;
        end
        FINAL: begin
          round_key_reg <= k_inv;
          io.plaintext  <= isb ^ k_inv;
          io.done       <= 1'b1;
          fsm           <= DONE_ST;
        end
        DONE_ST: begin
          io.done <= 1'b0;
          if (!io.start) begin
            io.busy <= 1'b0;
            fsm     <= IDLE;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes128_dec.sv
// Bench for aes128_dec: FIPS vectors, abort/retrigger cases and
// random loopback against a byte-level AES encrypt model.
`timescale 1ns/1ps
module tb_aes128_dec;

  logic clk = 1'b0;
  logic reset_n = 1'b1;

  aes128_dec_if io ();

  aes128_dec #(
    .ROUNDS (10),
    .PT_RST (128'd0)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .io      (io)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  logic [127:0] exp_q[$];
  int           lat_q[$];
  int           sedge_q[$];

  logic [127:0] m_key = '0;
  bit           m_cv = 1'b0;

  localparam logic [127:0] C1_K  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_K   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT  = 128'h3243f6a8885a308d313198a2e0370734;

  logic [7:0] sb[256];

  function automatic logic [7:0] xtime(input logic [7:0] a);
    logic [8:0] t;
    t = {a, 1'b0};
    if (t[8]) t = t ^ 9'h11b;
    return t[7:0];
  endfunction

  function automatic logic [7:0] tmul(input logic [7:0] a,
                                      input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = 0; x = a; y = b;
    while (y != 0) begin
      if (y[0]) p = p ^ x;
      x = xtime(x);
      y = y >> 1;
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] s;
    logic [7:0] c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 0;
      for (int y = 1; y < 256; y++)
        if (tmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8]
             ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sb[x] = s;
    end
  endtask

  function automatic logic [127:0] enc(input logic [127:0] pt,
                                       input logic [127:0] key);
    logic [7:0]   s[16];
    logic [7:0]   t[16];
    logic [31:0]  w[44];
    logic [31:0]  tmp;
    logic [7:0]   rc;
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]],
               sb[tmp[31:24]]} ^ {rc, 24'h0};
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++)
      s[i] = pt[127-8*i -: 8] ^ key[127-8*i -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          s[r+4*c] = t[r+4*((c+r)%4)];
      if (rnd < 10)
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = tmul(a0,2) ^ tmul(a1,3) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ tmul(a1,2) ^ tmul(a2,3) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ tmul(a2,2) ^ tmul(a3,3);
          s[4*c+3] = tmul(a0,3) ^ a1 ^ a2 ^ tmul(a3,2);
        end
      for (int i = 0; i < 16; i++)
        s[i] = s[i] ^ w[4*rnd + i/4][31-8*(i%4) -: 8];
    end
    o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  // expected start-to-done edges, tracking the optional key cache
  function automatic int exp_lat(input logic [127:0] k);
`ifdef AES_DEC_KEYCACHE_EN
    if (m_cv && k == m_key) return 11;
    m_cv  = 1'b1;
    m_key = k;
    return 21;
`else
    return 21 + 0 * int'(k[0]);
`endif
  endfunction

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n && io.done === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL spurious_done: got done at edge %0d, want none",
                 cyc);
      end else begin
        chk("plaintext", io.plaintext, exp_q.pop_front());
        chk("latency", 128'(cyc - sedge_q.pop_front()),
            128'(lat_q.pop_front()));
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (io.busy !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout: busy=%b after %0d cycles, want 0",
               io.busy, n);
    end
  endtask

  task automatic run(input logic [127:0] ct, input logic [127:0] k,
                     input logic [127:0] pt);
    @(negedge clk);
    exp_q.push_back(pt);
    lat_q.push_back(exp_lat(k));
    sedge_q.push_back(cyc + 1);
    io.start = 1'b1;
    io.ciphertext = ct;
    io.key = k;
    @(negedge clk);
    io.start = 1'b0;
    io.ciphertext = ~ct;
    io.key = ~k;
    wait_idle();
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  initial begin
    logic [127:0] k, pt, prev_k;
    int n;
    io.start = 1'b0;
    io.ciphertext = '0;
    io.key = '0;
    build_sbox();
    #2 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_plaintext", io.plaintext, 128'd0);
    chk("rst_done", 128'(io.done), 128'd0);
    chk("rst_busy", 128'(io.busy), 128'd0);
    reset_n = 1'b1;

    run(C1_CT, C1_K, C1_PT);
    run(B_CT, B_K, B_PT);

    // start toggled and inputs changed mid-run, then held across done
    @(negedge clk);
    exp_q.push_back(C1_PT);
    lat_q.push_back(exp_lat(C1_K));
    sedge_q.push_back(cyc + 1);
    io.start = 1'b1;
    io.ciphertext = C1_CT;
    io.key = C1_K;
    @(negedge clk);
    io.start = 1'b0;
    io.ciphertext = rnd128();
    repeat (4) @(negedge clk);
    io.start = 1'b1;
    io.ciphertext = rnd128();
    io.key = rnd128();
    @(negedge clk);
    io.start = 1'b0;
    @(negedge clk);
    io.start = 1'b1;
    n = 0;
    while (io.done !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    repeat (6) @(negedge clk);
    chk("held_start_busy", 128'(io.busy), 128'd1);
    chk("held_start_done", 128'(io.done), 128'd0);
    io.start = 1'b0;
    wait_idle();

    // asynchronous reset at edge 12 of a run
    @(negedge clk);
    io.start = 1'b1;
    io.ciphertext = C1_CT;
    io.key = C1_K;
    repeat (13) @(posedge clk);
    io.start = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("abort_plaintext", io.plaintext, 128'd0);
    chk("abort_done", 128'(io.done), 128'd0);
    chk("abort_busy", 128'(io.busy), 128'd0);
    m_cv = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    run(C1_CT, C1_K, C1_PT);
    run(C1_CT, C1_K, C1_PT);
    run(B_CT, B_K, B_PT);

    prev_k = B_K;
    for (int j = 0; j < 1000; j++) begin
      k  = ($urandom_range(0, 3) == 0) ? prev_k : rnd128();
      pt = rnd128();
      run(enc(pt, k), k, pt);
      prev_k = k;
    end

    repeat (4) @(negedge clk);
    chk("pending", 128'(exp_q.size()), 128'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
